ctrl_pipe_v3: RTL and testbench
===============================

Name: ctrl_pipe_v3

Overview:
Parametrised control-word pipeline that follows the instruction decoder. It carries the decoded control vector, destination register and valid bit through the ID/EX, EX/MEM and MEM/WB registers. It inserts bubbles on the CMUX select, on branch flush and on detected load-use hazards, and freezes on an external stall. It hands per-stage control fields to the datapath.

Parameters:
CTRL_W, 26, width of the decoder control word
LOAD_BIT, 0, index of the Load flag within the control word
REGWR_BIT, 3, index of the RegFileEnable flag within the control word
REG_AW, 5, register address width
CNT_W, 32, statistics counter width (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
ctrl_in  in  CTRL_W  control word from the decoder (ID stage)
cmux  in  1  1 = pass ctrl_in; 0 = force a bubble
id_valid  in  1  ID stage holds a real instruction
id_dest  in  REG_AW  resolved destination register of the ID instruction
id_rs  in  REG_AW  rs field of the ID instruction
id_rt  in  REG_AW  rt field of the ID instruction
flush  in  1  squash the ID instruction (branch/jump taken)
stall_in  in  1  global freeze (memory busy)
ex_ctrl  out  CTRL_W  ID/EX control word
mem_ctrl  out  CTRL_W  EX/MEM control word
wb_ctrl  out  CTRL_W  MEM/WB control word
ex_valid, mem_valid, wb_valid  out  1 each  stage valid bits
ex_dest, mem_dest, wb_dest  out  REG_AW each  stage destination registers
wb_regwrite  out  1  wb_valid & wb_ctrl[REGWR_BIT] & (wb_dest != 0)
hazard_stall  out  1  load-use detected; IF/ID must hold (combinational)
bubble_count  out  CNT_W  bubbles inserted (only with PIPE_STATS_EN)
stall_count  out  CNT_W  cycles frozen (only with PIPE_STATS_EN)

Behaviour:
- Reset: when reset_n=0 at a clk edge, every ctrl/dest/valid output and both counters go to 0. Reset has the highest priority and aborts any in-flight instruction.
- hazard_stall = ex_valid & ex_ctrl[LOAD_BIT] & (ex_dest != 0) & id_valid & (ex_dest==id_rs | ex_dest==id_rt). It is purely combinational and holds the same value while stall_in=1.
- Priority per edge: reset > stall_in > flush > hazard_stall > cmux=0 > normal.
- stall_in=1: all three stage registers hold their values. Nothing advances and no bubble is inserted.
- Otherwise MEM/WB <= EX/MEM and EX/MEM <= ID/EX, always, whatever happens at ID/EX.
- ID/EX load:
  - flush, hazard_stall, cmux=0 or id_valid=0: ctrl=0, dest=0, valid=0.
  - else: ctrl=ctrl_in, dest=id_dest, valid=1.
- Latency: an instruction accepted at edge N appears on ex_* after N, mem_* after N+1, and wb_* after N+2.
- A bubble is all-zero, so it never writes registers or memory. wb_regwrite is also masked for register 0.
- Simultaneous flush and hazard_stall: flush wins. The bubble is counted once.
- Hazard lifts automatically the next cycle, because the load has moved on to MEM. A back-to-back dependent load pair therefore costs exactly 1 bubble.
- No combinational path from any input to ex_/mem_/wb_ outputs; only hazard_stall is combinational.

Optional Feature:
- Macro: PIPE_STATS_EN.
- With the macro defined:
  - bubble_count increments on every unfrozen edge that loads a bubble into ID/EX while id_valid=1 (flush, hazard or cmux=0).
  - stall_count increments on every edge with stall_in=1.
  - Both counters saturate at all-ones and clear on reset.
- Without the macro: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset and flow:
  - Stimulus: reset_n=0 for 2 cycles, then ctrl_in=26'h0000408 (RegFileEnable set), id_dest=5, id_valid=1, cmux=1 for 1 cycle, then id_valid=0.
  - Required: all outputs 0 during reset; ex_ctrl=0x408 after edge 1, mem_ctrl after edge 2, wb_ctrl after edge 3 with wb_regwrite=1 and wb_dest=5.
- Load-use:
  - Stimulus: load (ctrl bit0=1, dest=8) followed by an instruction with id_rs=8.
  - Required: hazard_stall=1 for exactly 1 cycle, one bubble reaches EX, the dependent instruction then enters EX; bubble_count=1.
- Register 0:
  - Stimulus: load with dest=0 followed by an instruction with id_rt=0.
  - Required: hazard_stall stays 0; wb_regwrite stays 0 for the load.
- Flush vs hazard:
  - Stimulus: assert flush in the same cycle as a load-use hazard.
  - Required: a single bubble, ex_valid=0, bubble_count increments by exactly 1.
- Freeze:
  - Stimulus: three valid instructions in flight, stall_in=1 for 4 cycles.
  - Required: all stage outputs constant for 4 cycles, stall_count=4, then normal advance; reset_n=0 during the freeze clears everything.
- cmux and saturation:
  - Stimulus: cmux=0 with id_valid=1.
  - Required: ex_ctrl=0 and ex_valid=0.
  - Stimulus: with CNT_W=4, 20 bubbles.
  - Required: bubble_count=15 (saturated).

Source files
------------

// File: rtl/ctrl_pipe_v3.sv
// ctrl_pipe_v3: ID/EX, EX/MEM, MEM/WB control-word pipeline with bubbles.
// Optional PIPE_STATS_EN builds saturating bubble/stall counters.
module ctrl_pipe_v3 #(
  parameter int CTRL_W    = 26,
  parameter int LOAD_BIT  = 0,
  parameter int REGWR_BIT = 3,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              cmux,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              flush,
  input  logic              stall_in,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] ex_dest,
  output logic [REG_AW-1:0] mem_dest,
  output logic [REG_AW-1:0] wb_dest,
  output logic              wb_regwrite,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic [CTRL_W-1:0] ctrl;
  } stage_t;

  stage_t ex_q, mem_q, wb_q, ex_d;
  logic   take;
  logic   src_hit;

  assign src_hit = (ex_q.dest == id_rs)
                 | (ex_q.dest == id_rt);

  assign hazard_stall = ex_q.valid
                      & ex_q.ctrl[LOAD_BIT]
                      & (ex_q.dest != '0)
                      & id_valid
                      & src_hit;

  // A bubble is the all-zero record.
  assign take = id_valid & cmux
              & ~flush & ~hazard_stall;

  always_comb begin
    ex_d = '0;
    if (take) begin
      ex_d.valid = 1'b1;
      ex_d.dest  = id_dest;
      ex_d.ctrl  = ctrl_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!stall_in) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  assign ex_ctrl   = ex_q.ctrl;
  assign mem_ctrl  = mem_q.ctrl;
  assign wb_ctrl   = wb_q.ctrl;
  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;
  assign ex_dest   = ex_q.dest;
  assign mem_dest  = mem_q.dest;
  assign wb_dest   = wb_q.dest;

  assign wb_regwrite = wb_q.valid
                     & wb_q.ctrl[REGWR_BIT]
                     & (wb_q.dest != '0);

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] bub_q, stl_q;
  logic             bub_inc;

  assign bub_inc = ~stall_in & id_valid
                 & (flush | hazard_stall | ~cmux);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bub_q <= '0;
      stl_q <= '0;
    end else begin
      if (bub_inc && bub_q != '1)
        bub_q <= bub_q + 1'b1;
      if (stall_in && stl_q != '1)
        stl_q <= stl_q + 1'b1;
    end
  end

  assign bubble_count = bub_q;
  assign stall_count  = stl_q;
`else
  assign bubble_count = '0;
  assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_v3.sv
// tb_ctrl_pipe_v3: directed vector table, corner sequences and random
// stimulus checked against a queue-based pipeline model.
module tb_ctrl_pipe_v3;

  localparam int CW   = 26;
  localparam int AW   = 5;
  localparam int NW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] ctrl_in;
  logic          cmux, id_valid, flush, stall_in;
  logic [AW-1:0] id_dest, id_rs, id_rt;
  logic [CW-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic          ex_valid, mem_valid, wb_valid;
  logic [AW-1:0] ex_dest, mem_dest, wb_dest;
  logic          wb_regwrite, hazard_stall;
  logic [NW-1:0] bubble_count, stall_count;

  ctrl_pipe_v3 #(.CNT_W(NW)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in),
    .cmux(cmux), .id_valid(id_valid), .id_dest(id_dest),
    .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
    .stall_in(stall_in), .ex_ctrl(ex_ctrl),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .ex_dest(ex_dest),
    .mem_dest(mem_dest), .wb_dest(wb_dest),
    .wb_regwrite(wb_regwrite), .hazard_stall(hazard_stall),
    .bubble_count(bubble_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic [CW-1:0] ctrl;
    logic          cmux, idv, fl, st;
    logic [AW-1:0] dest, rs, rt;
    logic          e_hz, e_exv, e_wbrw;
    logic [AW-1:0] e_exd;
    logic [CW-1:0] e_exc;
  } vec_t;

  typedef struct {
    logic          v;
    logic [AW-1:0] d;
    logic [CW-1:0] c;
  } mrec_t;

  mrec_t pipe[$];
  int    m_bc, m_sc;
  int    errors = 0;
  int    checks = 0;
  vec_t  tbl[$];

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  function automatic logic m_haz();
    mrec_t x = pipe[0];
    return x.v && x.c[0] && x.d != 0 && id_valid
           && (x.d == id_rs || x.d == id_rt);
  endfunction

  task automatic m_reset();
    mrec_t z = '{v: 1'b0, d: '0, c: '0};
    pipe = {z, z, z};
    m_bc = 0;
    m_sc = 0;
  endtask

  task automatic m_step(logic hz);
    mrec_t n = '{v: 1'b0, d: '0, c: '0};
    if (!reset_n) begin
      m_reset();
    end else if (stall_in) begin
      m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    end else begin
      if (id_valid && (flush || hz || !cmux))
        m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
      if (id_valid && cmux && !flush && !hz)
        n = '{v: 1'b1, d: id_dest, c: ctrl_in};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic check_model();
    mrec_t w = pipe[2];
    chk("ex_ctrl", ex_ctrl, pipe[0].c);
    chk("ex_valid", ex_valid, pipe[0].v);
    chk("ex_dest", ex_dest, pipe[0].d);
    chk("mem_ctrl", mem_ctrl, pipe[1].c);
    chk("mem_valid", mem_valid, pipe[1].v);
    chk("mem_dest", mem_dest, pipe[1].d);
    chk("wb_ctrl", wb_ctrl, w.c);
    chk("wb_valid", wb_valid, w.v);
    chk("wb_dest", wb_dest, w.d);
    chk("wb_regwrite", wb_regwrite,
        w.v && w.c[3] && w.d != 0);
`ifdef PIPE_STATS_EN
    chk("bubble_count", bubble_count, m_bc);
    chk("stall_count", stall_count, m_sc);
`else
    chk("bubble_count", bubble_count, 0);
    chk("stall_count", stall_count, 0);
`endif
  endtask

  // Drive, check hazard before the edge, advance, check after it.
  task automatic cycle(vec_t v, output logic hz);
    reset_n  = v.rst_n;
    ctrl_in  = v.ctrl;
    cmux     = v.cmux;
    id_valid = v.idv;
    flush    = v.fl;
    stall_in = v.st;
    id_dest  = v.dest;
    id_rs    = v.rs;
    id_rt    = v.rt;
    #1;
    hz = m_haz();
    chk("hazard_model", hazard_stall, hz);
    hz = hazard_stall;
    @(posedge clk);
    m_step(m_haz());
    #1;
    check_model();
  endtask

  function automatic vec_t mk(
    logic r, logic [CW-1:0] c, logic cm, logic iv,
    logic fl, logic st, logic [AW-1:0] d,
    logic [AW-1:0] rs, logic [AW-1:0] rt,
    logic ehz, logic eexv, logic [AW-1:0] eexd,
    logic [CW-1:0] eexc, logic ewbrw);
    vec_t v;
    v.rst_n = r;  v.ctrl = c; v.cmux = cm; v.idv = iv;
    v.fl = fl;    v.st = st;  v.dest = d;  v.rs = rs;
    v.rt = rt;    v.e_hz = ehz; v.e_exv = eexv;
    v.e_exd = eexd; v.e_exc = eexc; v.e_wbrw = ewbrw;
    return v;
  endfunction

  initial begin
    logic hz;
    vec_t v;
    m_reset();
    // reset and flow
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h408, 1, 1, 0, 0, 5, 0, 0,
                     0, 1, 5, 'h408, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // load-use: one bubble, then dependent enters
    tbl.push_back(mk(1, 'h1, 1, 1, 0, 0, 8, 0, 0,
                     0, 1, 8, 'h1, 0));
    tbl.push_back(mk(1, 'h408, 1, 1, 0, 0, 9, 8, 2,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h408, 1, 1, 0, 0, 9, 8, 2,
                     0, 1, 9, 'h408, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // register 0 never hazards nor writes
    tbl.push_back(mk(1, 'h9, 1, 1, 0, 0, 0, 0, 0,
                     0, 1, 0, 'h9, 0));
    tbl.push_back(mk(1, 'h408, 1, 1, 0, 0, 4, 3, 0,
                     0, 1, 4, 'h408, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // flush together with hazard
    tbl.push_back(mk(1, 'h1, 1, 1, 0, 0, 7, 0, 0,
                     0, 1, 7, 'h1, 0));
    tbl.push_back(mk(1, 'h408, 1, 1, 1, 0, 6, 7, 0,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // freeze with three in flight
    tbl.push_back(mk(1, 'h408, 1, 1, 0, 0, 1, 0, 0,
                     0, 1, 1, 'h408, 0));
    tbl.push_back(mk(1, 'h408, 1, 1, 0, 0, 2, 0, 0,
                     0, 1, 2, 'h408, 0));
    tbl.push_back(mk(1, 'h408, 1, 1, 0, 0, 3, 0, 0,
                     0, 1, 3, 'h408, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 'h408, 1, 1, 0, 1, 4, 0, 0,
                       0, 1, 3, 'h408, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // reset during freeze
    tbl.push_back(mk(1, 'h408, 1, 1, 0, 0, 1, 0, 0,
                     0, 1, 1, 'h408, 1));
    tbl.push_back(mk(0, 'h408, 1, 1, 0, 1, 2, 0, 0,
                     0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // cmux=0 forces a bubble
    tbl.push_back(mk(1, 'h408, 0, 1, 0, 0, 5, 0, 0,
                     0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      cycle(tbl[i], hz);
      chk($sformatf("v%0d_hazard", i), hz, tbl[i].e_hz);
      chk($sformatf("v%0d_ex_valid", i), ex_valid, tbl[i].e_exv);
      chk($sformatf("v%0d_ex_dest", i), ex_dest, tbl[i].e_exd);
      chk($sformatf("v%0d_ex_ctrl", i), ex_ctrl, tbl[i].e_exc);
      chk($sformatf("v%0d_wb_regwrite", i), wb_regwrite,
          tbl[i].e_wbrw);
      if (i == 16) begin
`ifdef PIPE_STATS_EN
        chk("flush_haz_bubbles", bubble_count, 2);
`else
        chk("flush_haz_bubbles", bubble_count, 0);
`endif
      end
      if (i == 24) begin
`ifdef PIPE_STATS_EN
        chk("freeze_stalls", stall_count, 4);
`else
        chk("freeze_stalls", stall_count, 0);
`endif
      end
    end

    // saturation: 20 bubbles after a fresh reset
    v = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(v, hz);
    v = mk(1, 'h408, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(v, hz);
`ifdef PIPE_STATS_EN
    chk("bubble_saturate", bubble_count, CMAX);
`else
    chk("bubble_saturate", bubble_count, 0);
`endif

    // random traffic with a small register space to provoke hazards
    for (int i = 0; i < 600; i++) begin
      v.rst_n = ($urandom_range(0, 49) != 0);
      v.ctrl  = CW'($urandom());
      v.cmux  = ($urandom_range(0, 9) != 0);
      v.idv   = ($urandom_range(0, 4) != 0);
      v.fl    = ($urandom_range(0, 9) == 0);
      v.st    = ($urandom_range(0, 7) == 0);
      v.dest  = AW'($urandom_range(0, 3));
      v.rs    = AW'($urandom_range(0, 3));
      v.rt    = AW'($urandom_range(0, 3));
      cycle(v, hz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
